rvr32_brunit: RTL and testbench

RVR32_BRUNIT -- requirements
Module: rvr32_brunit

---
 rtl/rvr32_brunit.sv | 137 +++++++++++++
 tb/tb_rvr32_brunit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvr32_brunit.sv
// RV32 branch/jump resolution unit: captures a request, evaluates compare and target,
// then either issues a redirect to fetch or reports a not-taken/illegal/misaligned completion.
module rvr32_brunit #(
  parameter int unsigned C_EXT      = 0,
  parameter int unsigned FLUSH_PRIO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid_i,
  output logic        br_ready_o,
  input  logic [1:0]  br_kind_i,
  input  logic [2:0]  br_funct3_i,
  input  logic [31:0] br_rs1_i,
  input  logic [31:0] br_rs2_i,
  input  logic [31:0] br_pc_i,
  input  logic [31:0] br_imm_i,
  input  logic        flush_i,
  output logic        redir_valid_o,
  input  logic        redir_ready_i,
  output logic [31:0] redir_pc_o,
  output logic        res_valid_o,
  output logic        res_taken_o,
  output logic        res_illegal_o,
  output logic        res_misalign_o,
  output logic [31:0] res_link_o
);

  typedef enum logic [1:0] {StIdle, StEval, StRedir} state_e;

  localparam logic [1:0] KindBranch = 2'b00;
  localparam logic [1:0] KindJalr   = 2'b10;
  localparam logic [1:0] KindRsvd   = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  kind_q;
  logic [2:0]  funct3_q;
  logic [31:0] rs1_q, rs2_q, pc_q, imm_q;
  logic [31:0] redir_pc_q;
  logic        res_valid_q, res_taken_q, res_illegal_q, res_misalign_q;
  logic [31:0] res_link_q;

  logic        accept, eval_done, redir_done, go_redir;
  logic        illegal, taken, misalign, cmp, bad_align;
  logic [31:0] op_a, op_b, target_raw, target;

  assign accept = br_valid_i & br_ready_o & ~flush_i;

  // Signed compare is an unsigned compare with the sign bits flipped.
  always_comb begin
    op_a       = rs1_q ^ {~funct3_q[1], 31'b0};
    op_b       = rs2_q ^ {~funct3_q[1], 31'b0};
    cmp        = (funct3_q[2] ? (op_a < op_b) : (rs1_q == rs2_q)) ^ funct3_q[0];
    illegal    = (kind_q == KindRsvd) ||
                 ((kind_q == KindBranch) && !funct3_q[2] && funct3_q[1]);
    target_raw = ((kind_q == KindJalr) ? rs1_q : pc_q) + imm_q;
    target     = (kind_q == KindJalr) ? {target_raw[31:1], 1'b0} : target_raw;
    taken      = (kind_q == KindBranch) ? cmp : 1'b1;
    bad_align  = (C_EXT != 0) ? target[0] : (target[1:0] != 2'b00);
    misalign   = taken & ~illegal & bad_align;
    go_redir   = taken & ~illegal & ~misalign;
  end

  assign eval_done  = (state_q == StEval) & ~flush_i & ~go_redir;
  assign redir_done = (state_q == StRedir) & redir_ready_i & (~flush_i | (FLUSH_PRIO == 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StEval;
      StEval:  state_d = (!flush_i && go_redir) ? StRedir : StIdle;
      StRedir: if (redir_done || flush_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    br_ready_o    = (state_q == StIdle);
    redir_valid_o = (state_q == StRedir);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q         <= 2'b00;
      funct3_q       <= 3'b000;
      rs1_q          <= 32'h0;
      rs2_q          <= 32'h0;
      pc_q           <= 32'h0;
      imm_q          <= 32'h0;
      redir_pc_q     <= 32'h0;
      res_valid_q    <= 1'b0;
      res_taken_q    <= 1'b0;
      res_illegal_q  <= 1'b0;
      res_misalign_q <= 1'b0;
      res_link_q     <= 32'h0;
    end else begin
      res_valid_q <= eval_done | redir_done;
      if (accept) begin
        kind_q   <= br_kind_i;
        funct3_q <= br_funct3_i;
        rs1_q    <= br_rs1_i;
        rs2_q    <= br_rs2_i;
        pc_q     <= br_pc_i;
        imm_q    <= br_imm_i;
      end
      if ((state_q == StEval) && !flush_i && go_redir) begin
        redir_pc_q <= target;
      end
      if (eval_done) begin
        res_taken_q    <= 1'b0;
        res_illegal_q  <= illegal;
        res_misalign_q <= misalign;
        res_link_q     <= pc_q + 32'd4;
      end else if (redir_done) begin
        res_taken_q    <= 1'b1;
        res_illegal_q  <= 1'b0;
        res_misalign_q <= 1'b0;
        res_link_q     <= pc_q + 32'd4;
      end
    end
  end

  assign redir_pc_o     = redir_pc_q;
  assign res_valid_o    = res_valid_q;
  assign res_taken_o    = res_taken_q;
  assign res_illegal_o  = res_illegal_q;
  assign res_misalign_o = res_misalign_q;
  assign res_link_o     = res_link_q;

endmodule

// File: tb/tb_rvr32_brunit.sv
// Directed bench for rvr32_brunit: two instances (C_EXT=0/FLUSH_PRIO=1 and C_EXT=1/FLUSH_PRIO=0)
// share stimulus; outputs are sampled on the falling edge.
module tb_rvr32_brunit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid, flush, redir_ready;
  logic [1:0]  br_kind;
  logic [2:0]  br_funct3;
  logic [31:0] br_rs1, br_rs2, br_pc, br_imm;

  logic        rdy0, rv0, resv0, tk0, il0, ma0;
  logic [31:0] rpc0, lnk0;
  logic        rdy1, rv1, resv1, tk1, il1, ma1;
  logic [31:0] rpc1, lnk1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rvr32_brunit #(.C_EXT(0), .FLUSH_PRIO(1)) u0 (
    .clk(clk), .rst_n(rst_n), .br_valid_i(br_valid), .br_ready_o(rdy0), .br_kind_i(br_kind),
    .br_funct3_i(br_funct3), .br_rs1_i(br_rs1), .br_rs2_i(br_rs2), .br_pc_i(br_pc),
    .br_imm_i(br_imm), .flush_i(flush), .redir_valid_o(rv0), .redir_ready_i(redir_ready),
    .redir_pc_o(rpc0), .res_valid_o(resv0), .res_taken_o(tk0), .res_illegal_o(il0),
    .res_misalign_o(ma0), .res_link_o(lnk0)
  );

  rvr32_brunit #(.C_EXT(1), .FLUSH_PRIO(0)) u1 (
    .clk(clk), .rst_n(rst_n), .br_valid_i(br_valid), .br_ready_o(rdy1), .br_kind_i(br_kind),
    .br_funct3_i(br_funct3), .br_rs1_i(br_rs1), .br_rs2_i(br_rs2), .br_pc_i(br_pc),
    .br_imm_i(br_imm), .flush_i(flush), .redir_valid_o(rv1), .redir_ready_i(redir_ready),
    .redir_pc_o(rpc1), .res_valid_o(resv1), .res_taken_o(tk1), .res_illegal_o(il1),
    .res_misalign_o(ma1), .res_link_o(lnk1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic req(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm);
    br_kind = k; br_funct3 = f3; br_rs1 = a; br_rs2 = b; br_pc = pc; br_imm = imm;
    br_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; flush = 1'b0; redir_ready = 1'b0;
    br_kind = 2'b00; br_funct3 = 3'b000;
    br_rs1 = 32'h0; br_rs2 = 32'h0; br_pc = 32'h0; br_imm = 32'h0;

    // Reset values
    step();
    chk("rst_ready", rdy0, 1);
    chk("rst_redir_valid", rv0, 0);
    chk("rst_res_valid", resv0, 0);
    chk("rst_redir_pc", rpc0, 0);
    chk("rst_res_link", lnk0, 0);
    chk("rst_flags", {tk0, il0, ma0}, 0);
    rst_n = 1'b1;

    // BEQ taken, redirect to 0x120
    req(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
    redir_ready = 1'b1;
    step();
    br_valid = 1'b0;
    chk("beq_eval_ready", rdy0, 0);
    chk("beq_eval_rv", rv0, 0);
    step();
    chk("beq_rv", rv0, 1);
    chk("beq_rpc", rpc0, 32'h120);
    chk("beq_rpc_cext1", rpc1, 32'h120);
    step();
    chk("beq_resv", resv0, 1);
    chk("beq_taken", tk0, 1);
    chk("beq_link", lnk0, 32'h104);
    chk("beq_rv_drop", rv0, 0);
    chk("beq_idle", rdy0, 1);

    // BLT signed -1 < 1: taken
    req(2'b00, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
    step();
    br_valid = 1'b0;
    step();
    chk("blt_rv", rv0, 1);
    chk("blt_rpc", rpc0, 32'h240);
    step();
    chk("blt_resv", resv0, 1);
    chk("blt_taken", tk0, 1);
    // BLTU back-to-back, same operands: not taken
    req(2'b00, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40);
    step();
    br_valid = 1'b0;
    chk("bltu_accepted", rdy0, 0);
    chk("blt_pulse_one", resv0, 0);
    step();
    chk("bltu_resv", resv0, 1);
    chk("bltu_taken", tk0, 0);
    chk("bltu_no_rv", rv0, 0);
    chk("bltu_link", lnk0, 32'h304);
    chk("bltu_illegal", il0, 0);
    step();
    chk("bltu_hold_link", lnk0, 32'h304);
    chk("bltu_pulse_end", resv0, 0);

    // JALR to 0x1003: misaligned for C_EXT=0, redirect to 0x1002 for C_EXT=1
    req(2'b10, 3'b000, 32'h1003, 32'h0, 32'h400, 32'h0);
    step();
    br_valid = 1'b0;
    step();
    chk("jalr_c0_resv", resv0, 1);
    chk("jalr_c0_misalign", ma0, 1);
    chk("jalr_c0_no_rv", rv0, 0);
    chk("jalr_c1_rv", rv1, 1);
    chk("jalr_c1_rpc", rpc1, 32'h1002);
    step();
    chk("jalr_c1_resv", resv1, 1);
    chk("jalr_c1_taken", tk1, 1);
    chk("jalr_c1_link", lnk1, 32'h404);
    chk("jalr_c0_hold_ma", ma0, 1);

    // Illegal funct3 010
    req(2'b00, 3'b010, 32'd1, 32'd1, 32'h500, 32'h8);
    step();
    br_valid = 1'b0;
    step();
    chk("ill_f3_resv", resv0, 1);
    chk("ill_f3_illegal", il0, 1);
    chk("ill_f3_taken", tk0, 0);
    chk("ill_f3_no_rv", rv0, 0);
    chk("ill_f3_misalign", ma0, 0);
    // Reserved kind 11
    req(2'b11, 3'b000, 32'd0, 32'd0, 32'h520, 32'h8);
    step();
    br_valid = 1'b0;
    step();
    chk("ill_kind_resv", resv1, 1);
    chk("ill_kind_illegal", il1, 1);
    chk("ill_kind_no_rv", rv1, 0);

    // BNE taken, redir_ready held low; flush on third REDIR cycle
    redir_ready = 1'b0;
    req(2'b00, 3'b001, 32'd1, 32'd2, 32'h500, 32'h10);
    step();
    br_valid = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      chk("hold_rv", rv0, 1);
      chk("hold_rpc", rpc0, 32'h510);
      chk("hold_resv", resv0, 0);
      step();
    end
    chk("hold_rv3", rv0, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_rv", rv0, 0);
    chk("flush_idle", rdy0, 1);
    chk("flush_resv", resv0, 0);
    step();
    chk("flush_resv_late", resv0, 0);

    // Flush together with redir_ready: PRIO=1 drops, PRIO=0 completes
    req(2'b00, 3'b000, 32'd7, 32'd7, 32'h600, 32'h4);
    step();
    br_valid = 1'b0;
    step();
    chk("fr_rv0", rv0, 1);
    chk("fr_rv1", rv1, 1);
    flush = 1'b1;
    redir_ready = 1'b1;
    step();
    flush = 1'b0;
    redir_ready = 1'b0;
    chk("fr_p1_resv", resv0, 0);
    chk("fr_p1_rv", rv0, 0);
    chk("fr_p0_resv", resv1, 1);
    chk("fr_p0_taken", tk1, 1);
    chk("fr_p0_link", lnk1, 32'h604);
    chk("fr_p0_rv", rv1, 0);

    // Flush while in EVAL
    req(2'b01, 3'b000, 32'd0, 32'd0, 32'h700, 32'h100);
    step();
    br_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fe_rv", rv0, 0);
    chk("fe_resv", resv0, 0);
    chk("fe_idle", rdy0, 1);
    step();
    chk("fe_resv_late", resv0, 0);

    // Asynchronous reset while in REDIR
    req(2'b01, 3'b000, 32'd0, 32'd0, 32'h800, 32'h10);
    step();
    br_valid = 1'b0;
    step();
    chk("ar_rv_pre", rv0, 1);
    chk("ar_rpc_pre", rpc0, 32'h810);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rv", rv0, 0);
    chk("ar_ready", rdy0, 1);
    chk("ar_rpc", rpc0, 0);
    chk("ar_link", lnk0, 0);
    chk("ar_flags", {resv0, tk0, il0, ma0}, 0);
    step();
    // Release and accept on the first rising edge: BEQ not taken
    rst_n = 1'b1;
    req(2'b00, 3'b000, 32'd1, 32'd2, 32'h900, 32'h8);
    step();
    br_valid = 1'b0;
    chk("post_rst_accept", rdy0, 0);
    chk("post_rst_no_resv", resv0, 0);
    step();
    chk("post_rst_resv", resv0, 1);
    chk("post_rst_taken", tk0, 0);
    chk("post_rst_link", lnk0, 32'h904);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
